// File: rtl/ysyx_22040127_exu_muldiv_pkg.sv
// Shared op codes, FSM state type and operand-signedness helpers for the M-extension unit.
package ysyx_22040127_exu_muldiv_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_OP_MUL    = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_OP_MULH   = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_OP_MULHSU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_OP_MULHU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_OP_DIV    = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_OP_DIVU   = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_OP_REM    = 3'd6;
    localparam logic [MD_OP_W-1:0] MD_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_e;

    function automatic logic op_src1_signed(input logic [MD_OP_W-1:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) || (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

    function automatic logic op_src2_signed(input logic [MD_OP_W-1:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/ysyx_22040127_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle over the low `len` bits of the dividend.
module ysyx_22040127_div_core #(
    parameter int XLEN  = 64,
    parameter int LEN_W = $clog2(XLEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    input  logic [LEN_W-1:0] len,
    output logic             done,
    output logic [XLEN-1:0]  quo,
    output logic [XLEN-1:0]  rem
);

    logic [XLEN-1:0]  dvsr;
    logic [LEN_W-1:0] cnt;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    diff;

    assign rem_shift = {rem, quo[XLEN-1]};
    assign diff      = rem_shift - {1'b0, dvsr};

    // Short ops pre-shift the dividend so its bit len-1 is the first to enter the remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
            quo  <= '0;
            rem  <= '0;
            dvsr <= '0;
        end else if (start) begin
            cnt  <= len;
            done <= 1'b0;
            rem  <= '0;
            dvsr <= divisor;
            quo  <= dividend << (LEN_W'(XLEN) - len);
        end else if (cnt != '0) begin
            rem  <= diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
            quo  <= {quo[XLEN-2:0], ~diff[XLEN]};
            cnt  <= cnt - LEN_W'(1);
            done <= (cnt == LEN_W'(1));
        end
    end

endmodule

// File: rtl/ysyx_22040127_exu_muldiv.sv
// Iterative RV M-extension unit: shift-add multiplier, restoring divider, single-cycle special cases.
//  state | meaning
//  IDLE  | ready to accept a request
//  MUL   | shift-add iterations, MUL_STEP multiplier bits per cycle
//  DIV   | waiting for the divider core
//  DONE  | result presented (special cases raise out_valid on entry + 1 cycle)
module ysyx_22040127_exu_muldiv
    import ysyx_22040127_exu_muldiv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 2,
    parameter int W_EN     = 1,
    parameter int TAG_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic               in_word,
    input  logic [XLEN-1:0]    in_src1,
    input  logic [XLEN-1:0]    in_src2,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int LEN_W = $clog2(XLEN) + 1;
    localparam int PW    = XLEN + MUL_STEP;
    localparam logic [LEN_W-1:0] MUL_ITER   = LEN_W'(XLEN / MUL_STEP);
    localparam logic [LEN_W-1:0] MUL_ITER_W = LEN_W'(32 / MUL_STEP);

    function automatic logic [XLEN-1:0] wext(input logic [31:0] x, input logic s);
        logic [XLEN-1:0] r;
        r       = (s && x[31]) ? '1 : '0;
        r[31:0] = x;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] fmt(input logic w, input logic [XLEN-1:0] r);
        return w ? wext(r[31:0], 1'b1) : r;
    endfunction

    md_state_e        state;
    logic [2:0]       op_q;
    logic             word_q, neg1_q, neg2_q;
    logic [XLEN-1:0]  a_q, hi_q, lo_q;
    logic [LEN_W-1:0] mcnt;

    logic             word_in, s1, s2, neg1, neg2, is_div, div0, ovf, special, accept;
    logic [XLEN-1:0]  ext1, ext2, mag1, mag2, min_v, spec_res;

    assign word_in  = (W_EN != 0) && (XLEN == 64) && in_word;
    assign s1       = op_src1_signed(in_op);
    assign s2       = op_src2_signed(in_op);
    assign ext1     = word_in ? wext(in_src1[31:0], s1) : in_src1;
    assign ext2     = word_in ? wext(in_src2[31:0], s2) : in_src2;
    assign neg1     = s1 & ext1[XLEN-1];
    assign neg2     = s2 & ext2[XLEN-1];
    assign mag1     = neg1 ? -ext1 : ext1;
    assign mag2     = neg2 ? -ext2 : ext2;
    assign is_div   = in_op[2];
    assign min_v    = word_in ? wext(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    assign div0     = (ext2 == '0);
    assign ovf      = s1 && (ext1 == min_v) && (ext2 == '1);
    assign special  = is_div & (div0 | ovf);
    assign spec_res = in_op[1] ? (div0 ? fmt(word_in, ext1) : '0)
                               : (div0 ? '1 : min_v);
    assign accept   = in_valid & (state == ST_IDLE) & ~flush;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    logic             div_done;
    logic [XLEN-1:0]  div_quo, div_rem;

    ysyx_22040127_div_core #(.XLEN(XLEN), .LEN_W(LEN_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept & is_div & ~special),
        .dividend (mag1),
        .divisor  (mag2),
        .len      (word_in ? LEN_W'(32) : LEN_W'(XLEN)),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    logic [PW-1:0]     partial, step_sum;
    logic [2*XLEN-1:0] prod_u, prod_s;
    logic [XLEN-1:0]   mul_res, div_res;

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_STEP; j++)
            if (lo_q[j]) partial = partial + (PW'(a_q) << j);
        step_sum = PW'(hi_q) + partial;
    end

    // Word products sit 32 bits higher since only half the multiplier has been shifted out.
    assign prod_u  = word_q ? ({hi_q, lo_q} >> 32) : {hi_q, lo_q};
    assign prod_s  = (neg1_q ^ neg2_q) ? -prod_u : prod_u;
    assign mul_res = (op_q == MD_OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    assign div_res = op_q[1] ? (neg1_q ? -div_rem : div_rem)
                             : ((neg1_q ^ neg2_q) ? -div_quo : div_quo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            op_q       <= '0;
            word_q     <= 1'b0;
            neg1_q     <= 1'b0;
            neg2_q     <= 1'b0;
            a_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mcnt       <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    op_q    <= in_op;
                    word_q  <= word_in;
                    neg1_q  <= neg1;
                    neg2_q  <= neg2;
                    out_tag <= in_tag;
                    a_q     <= mag1;
                    hi_q    <= '0;
                    lo_q    <= mag2;
                    mcnt    <= word_in ? MUL_ITER_W : MUL_ITER;
                    if (special) begin
                        out_result <= spec_res;
                        state      <= ST_DONE;
                    end else begin
                        state <= is_div ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: if (mcnt != '0) begin
                    hi_q <= step_sum[PW-1:MUL_STEP];
                    lo_q <= {step_sum[MUL_STEP-1:0], lo_q[XLEN-1:MUL_STEP]};
                    mcnt <= mcnt - LEN_W'(1);
                end else begin
                    out_result <= fmt(word_q, mul_res);
                    out_valid  <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DIV: if (div_done) begin
                    out_result <= fmt(word_q, div_res);
                    out_valid  <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040127_exu_muldiv.sv
// Directed bench for the M-extension unit: latencies, results, tags, hold, flush and reset.
module tb_ysyx_22040127_exu_muldiv;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_word, out_ready;
    logic        in_ready, out_valid, busy;
    logic [2:0]  in_op;
    logic [63:0] in_src1, in_src2, out_result;
    logic [4:0]  in_tag, out_tag;

    int checks = 0;
    int errors = 0;

    ysyx_22040127_exu_muldiv #(.XLEN(64), .MUL_STEP(2), .W_EN(1), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_word    (in_word),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_word = w;
        in_src1 = a; in_src2 = b; in_tag = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_tag = '0; in_op = '0; in_word = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        chk({tag, " valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] t, output int lat,
                       output logic [63:0] res, output logic [4:0] otag);
        issue(op, w, a, b, t);
        wait_valid(tag, lat);
        res  = out_result;
        otag = out_tag;
        take();
    endtask

    int          lat;
    logic [63:0] res;
    logic [4:0]  otag;
    logic        seen;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = 1'b0; out_ready = 1'b0;
        in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_result", out_result, 64'd0);
        chk("rst out_tag", 64'(out_tag), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        run("mul", 3'd0, 1'b0, 64'd7, -64'sd3, 5'd1, lat, res, otag);
        chk("mul lat", 64'(lat), 64'd33);
        chk("mul res", res, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul tag", 64'(otag), 64'd1);

        run("mulhu", 3'd3, 1'b0, '1, '1, 5'd2, lat, res, otag);
        chk("mulhu res", res, 64'hFFFF_FFFF_FFFF_FFFE);
        run("mulhsu", 3'd2, 1'b0, '1, 64'd2, 5'd2, lat, res, otag);
        chk("mulhsu res", res, 64'hFFFF_FFFF_FFFF_FFFF);
        run("mulh", 3'd1, 1'b0, -64'sd4, 64'h4000_0000_0000_0000, 5'd2, lat, res, otag);
        chk("mulh res", res, 64'hFFFF_FFFF_FFFF_FFFF);

        run("div", 3'd4, 1'b0, -64'sd7, 64'd2, 5'd5, lat, res, otag);
        chk("div lat", 64'(lat), 64'd65);
        chk("div res", res, 64'hFFFF_FFFF_FFFF_FFFD);
        run("rem", 3'd6, 1'b0, -64'sd7, 64'd2, 5'd6, lat, res, otag);
        chk("rem lat", 64'(lat), 64'd65);
        chk("rem res", res, 64'hFFFF_FFFF_FFFF_FFFF);
        run("divuw", 3'd5, 1'b1, 64'h1_0000_0007, 64'd2, 5'd7, lat, res, otag);
        chk("divuw lat", 64'(lat), 64'd33);
        chk("divuw res", res, 64'd3);
        run("remu", 3'd7, 1'b0, 64'd100, 64'd7, 5'd7, lat, res, otag);
        chk("remu res", res, 64'd2);

        run("div0", 3'd4, 1'b0, 64'd123, 64'd0, 5'd8, lat, res, otag);
        chk("div0 lat", 64'(lat), 64'd1);
        chk("div0 res", res, 64'hFFFF_FFFF_FFFF_FFFF);
        run("remu0", 3'd7, 1'b0, 64'd5, 64'd0, 5'd9, lat, res, otag);
        chk("remu0 lat", 64'(lat), 64'd1);
        chk("remu0 res", res, 64'd5);
        run("divovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd10, lat, res, otag);
        chk("divovf lat", 64'(lat), 64'd1);
        chk("divovf res", res, 64'h8000_0000_0000_0000);
        run("removf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11, lat, res, otag);
        chk("removf lat", 64'(lat), 64'd1);
        chk("removf res", res, 64'd0);
        chk("removf tag", 64'(otag), 64'd11);

        // Result held while the consumer stalls.
        issue(3'd0, 1'b0, 64'd6, 64'd7, 5'd9);
        wait_valid("hold", lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold valid", 64'(out_valid), 64'd1);
            chk("hold res", out_result, 64'd42);
            chk("hold tag", 64'(out_tag), 64'd9);
            chk("hold in_ready", 64'(in_ready), 64'd0);
        end
        take();
        chk("take valid", 64'(out_valid), 64'd0);
        chk("take in_ready", 64'(in_ready), 64'd1);

        // Flush mid-divide, then a fresh op.
        issue(3'd4, 1'b0, 64'd100, 64'd7, 5'd12);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        chk("flush no valid", 64'(seen), 64'd0);
        run("post flush", 3'd4, 1'b0, 64'd100, 64'd7, 5'd13, lat, res, otag);
        chk("post flush res", res, 64'd14);
        chk("post flush tag", 64'(otag), 64'd13);

        // Reset mid-operation.
        issue(3'd5, 1'b0, 64'd100, 64'd7, 5'd14);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst valid", 64'(out_valid), 64'd0);
        chk("midrst tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back word ops, tags returned in order.
        run("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd3, lat, res, otag);
        chk("mulw lat", 64'(lat), 64'd17);
        chk("mulw res", res, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mulw tag", 64'(otag), 64'd3);
        run("divw", 3'd4, 1'b1, 64'h0000_0000_FFFF_FFEC, 64'd3, 5'd4, lat, res, otag);
        chk("divw lat", 64'(lat), 64'd33);
        chk("divw res", res, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("divw tag", 64'(otag), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
